// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int BAUD_COUNT_DEF = 5207;

  function automatic logic parity_of(
    input logic [7:0] b,
    input int         mode
  );
    return (mode == PARITY_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with clear.
// Tick marks the last cycle of each bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT = BAUD_COUNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(BAUD_COUNT);

  logic [15:0] cnt;

  assign tick = en && (cnt == LAST);

  // count 0..LAST while enabled, wrap, hold at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N/8P, 1 or 2 stop bit transmitter.
// One-entry holding register allows gap-free frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT = BAUD_COUNT_DEF,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_LINE,
  output logic       BUSY,
  output logic       DONE
);

  localparam bit HAS_PAR = (PARITY != PARITY_NONE);
  localparam logic [2:0] STOP_LAST =
    (STOP_BITS == 2) ? 3'd1 : 3'd0;

  tx_state_e  state, state_n;
  logic [7:0] shift, shift_n;
  logic [7:0] hold;
  logic       hold_full;
  logic       par_bit;
  logic [2:0] idx;
  logic       tick;
  logic       load;
  logic       done_n;
  logic       line_n;
  logic       accept;

  assign TX_READY = !hold_full;
  assign accept   = TX_VALID && !hold_full;

  uart_baud_tick #(
    .BAUD_COUNT(BAUD_COUNT)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != ST_IDLE),
    .clear(load),
    .tick (tick)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state, shifter load/shift, next line level
  always_comb begin
    state_n = state;
    shift_n = shift;
    load    = 1'b0;
    done_n  = 1'b0;
    line_n  = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (hold_full) begin
          state_n = ST_START;
          load    = 1'b1;
          shift_n = hold;
        end
      end
      ST_START: begin
        if (tick) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7)
            state_n = HAS_PAR ? ST_PARITY
                              : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (tick && idx == STOP_LAST) begin
          done_n = 1'b1;
          if (hold_full) begin
            state_n = ST_START;
            load    = 1'b1;
            shift_n = hold;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    case (state_n)
      ST_START:  line_n = 1'b0;
      ST_DATA:   line_n = shift_n[0];
      ST_PARITY: line_n = par_bit;
      default:   line_n = 1'b1;
    endcase
  end

  // datapath, holding register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      idx       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      TX_LINE   <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      shift   <= shift_n;
      TX_LINE <= line_n;
      BUSY    <= (state_n != ST_IDLE);
      DONE    <= done_n;
      if (state_n != state) begin
        idx <= '0;
      end else if (tick) begin
        idx <= idx + 3'd1;
      end
      if (load) begin
        par_bit <= parity_of(hold, PARITY);
      end
      if (accept) begin
        hold      <= TX_DATA;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed plus random frames against
// a bit-list model of the UART frame.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NI = 5;
  localparam int BCS[NI] = '{3, 3, 3, 3, BAUD_COUNT_DEF};
  localparam int PS[NI]  = '{0, 2, 1, 0, 0};
  localparam int SS[NI]  = '{1, 1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d    [NI];
  logic       v    [NI];
  logic       rdy  [NI];
  logic       line [NI];
  logic       busy [NI];
  logic       done [NI];

  int checks = 0;
  int errors = 0;

  bit         cap_line[$];
  bit         cap_busy[$];
  bit         cap_done[$];
  bit         cap_rdy[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx #(
      .BAUD_COUNT(BCS[g]),
      .PARITY    (PS[g]),
      .STOP_BITS (SS[g])
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .TX_DATA (d[g]),
      .TX_VALID(v[g]),
      .TX_READY(rdy[g]),
      .TX_LINE (line[g]),
      .BUSY    (busy[g]),
      .DONE    (done[g])
    );
  end

  task automatic chk(input string tag, input int c,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, c, obs, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return 9 + ((PS[i] != 0) ? 1 : 0) + SS[i];
  endfunction

  // bit k of the frame for byte b, from the framing rules
  function automatic bit frame_bit(input int i,
                                   input logic [7:0] b,
                                   input int k);
    int ones;
    ones = $countones(b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PS[i] != 0 && k == 9)
      return (PS[i] == 2) ? (ones % 2 == 1)
                          : (ones % 2 == 0);
    return 1'b1;
  endfunction

  // drive txq through the handshake, capture n samples
  task automatic run(input int i, input int n);
    bit pend;
    logic [7:0] tmp;
    pend = 1'b0;
    cap_line.delete();
    cap_busy.delete();
    cap_done.delete();
    cap_rdy.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_line.push_back(line[i]);
      cap_busy.push_back(busy[i]);
      cap_done.push_back(done[i]);
      cap_rdy.push_back(rdy[i]);
      if (pend) tmp = txq.pop_front();
      if (txq.size() > 0) begin
        d[i] = txq[0];
        v[i] = 1'b1;
      end else begin
        d[i] = 8'($urandom);
        v[i] = 1'b0;
      end
      pend = v[i] && rdy[i];
    end
  endtask

  task automatic check_run(input string tag, input int i,
                           input logic [7:0] bq[$]);
    int bp, t, nb, rel, nbusy, ndone;
    bit el, eb, ed, er;
    bp = BCS[i] + 1;
    t  = frame_len(i) * bp;
    nb = bq.size();
    nbusy = 0;
    ndone = 0;
    for (int c = 0; c < cap_line.size(); c++) begin
      rel = c - 2;
      el = 1'b1;
      eb = 1'b0;
      ed = 1'b0;
      if (rel >= 0 && rel < nb * t) begin
        el = frame_bit(i, bq[rel / t], (rel % t) / bp);
        eb = 1'b1;
      end
      if (rel > 0 && rel % t == 0 && rel / t <= nb) ed = 1'b1;
      er = !(c == 1 || (nb == 2 && c >= 3 && c < 2 + t));
      chk({tag, ".line"}, c, 32'(cap_line[c]), 32'(el));
      chk({tag, ".busy"}, c, 32'(cap_busy[c]), 32'(eb));
      chk({tag, ".done"}, c, 32'(cap_done[c]), 32'(ed));
      chk({tag, ".ready"}, c, 32'(cap_rdy[c]), 32'(er));
      nbusy += int'(cap_busy[c]);
      ndone += int'(cap_done[c]);
    end
    chk({tag, ".busy_cycles"}, 0, 32'(nbusy), 32'(nb * t));
    chk({tag, ".done_pulses"}, 0, 32'(ndone), 32'(nb));
  endtask

  task automatic do_test(input string tag, input int i,
                         input logic [7:0] bq[$]);
    int t;
    t = frame_len(i) * (BCS[i] + 1);
    txq = bq;
    run(i, 2 + bq.size() * t + 4);
    check_run(tag, i, bq);
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] rx;
    logic [7:0] rbytes[2];
    int ri, rn, mid;
    for (int i = 0; i < NI; i++) begin
      d[i] = 8'h00;
      v[i] = 1'b0;
    end

    // reset state of every configuration
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst.line", i, 32'(line[i]), 32'd1);
      chk("rst.busy", i, 32'(busy[i]), 32'd0);
      chk("rst.done", i, 32'(done[i]), 32'd0);
      chk("rst.ready", i, 32'(rdy[i]), 32'd1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    bq = '{8'h55};
    do_test("single55", 0, bq);
    bq = '{8'hA5, 8'h3C};
    do_test("b2b", 0, bq);
    bq = '{8'h07};
    do_test("par_even", 1, bq);
    do_test("par_odd", 2, bq);
    bq = '{8'hFF};
    do_test("stop2", 3, bq);

    // random byte streams on the short-baud configurations
    for (int r = 0; r < 10; r++) begin
      ri = $urandom_range(0, 3);
      rn = $urandom_range(1, 2);
      rbytes[0] = 8'($urandom);
      rbytes[1] = 8'($urandom);
      bq.delete();
      for (int k = 0; k < rn; k++) bq.push_back(rbytes[k]);
      do_test("rand", ri, bq);
    end

    // reset during data bit 3 with a byte held
    for (int r = 0; r < 2; r++) begin
      txq = '{(r == 0) ? 8'h0F : 8'h00, 8'hF0};
      run(0, 2 + 4 * 4 + 2);
      chk("mid.busy_before", r, 32'(busy[0]), 32'd1);
      chk("mid.ready_before", r, 32'(rdy[0]), 32'd0);
      chk("mid.line_before", r, 32'(line[0]),
          (r == 0) ? 32'd1 : 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid.line", r, 32'(line[0]), 32'd1);
      chk("mid.busy", r, 32'(busy[0]), 32'd0);
      chk("mid.ready", r, 32'(rdy[0]), 32'd1);
      chk("mid.done", r, 32'(done[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      txq.delete();
      run(0, 60);
      for (int c = 0; c < 60; c++) begin
        chk("post.line", c, 32'(cap_line[c]), 32'd1);
        chk("post.busy", c, 32'(cap_busy[c]), 32'd0);
        chk("post.done", c, 32'(cap_done[c]), 32'd0);
      end
    end

    // full-rate frame, decoded at bit centres
    bq = '{8'hC3};
    do_test("loop", 4, bq);
    rx = 8'h00;
    for (int k = 0; k < 10; k++) begin
      mid = 2 + k * 5208 + 2604;
      if (k == 0)
        chk("loop.start", k, 32'(cap_line[mid]), 32'd0);
      else if (k == 9)
        chk("loop.stop", k, 32'(cap_line[mid]), 32'd1);
      else
        rx[k-1] = cap_line[mid];
    end
    chk("loop.rx_byte", 0, 32'(rx), 32'hC3);
    chk("loop.done_at", 0, 32'(cap_done[2 + 52080]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
